// File: rtl/dmem_bridge_pkg.sv
// Shared constants for the data-memory bridge: FSM state encoding, MMIO
// region default and the error word returned when an MMIO access times out.
package dmem_bridge_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IO_REQ  = 2'd1;
  localparam logic [1:0] ST_IO_RESP = 2'd2;

  localparam logic [3:0]  IO_BASE_DEFAULT = 4'h8;
  localparam logic [31:0] IO_ERR_DATA     = 32'hDEADBEEF;

  function automatic logic is_io_region(input logic [3:0] region, input logic [3:0] base);
    return region == base;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Processor, data-RAM and MMIO signals of the bridge; slave is the bridge
// side, master the surrounding system (processor, RAM and MMIO fabric).
interface dmem_bridge_if #(
  parameter int RAM_AW = 16
);
  logic [31:0]       mem_addr;
  logic [3:0]        mem_oe;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_valid;
  logic              mem_ready;

  logic [RAM_AW-1:0] ram_addr;
  logic [3:0]        ram_oe;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [31:0]       io_addr;
  logic [3:0]        io_we;
  logic [31:0]       io_wdata;
  logic              io_req;
  logic              io_ack;
  logic [31:0]       io_rdata;

  modport slave (
    input  mem_addr, mem_oe, mem_we, mem_wdata, ram_rdata, io_ack, io_rdata,
    output mem_rdata, mem_valid, mem_ready, ram_addr, ram_oe, ram_we, ram_wdata,
           io_addr, io_we, io_wdata, io_req
  );

  modport master (
    output mem_addr, mem_oe, mem_we, mem_wdata, ram_rdata, io_ack, io_rdata,
    input  mem_rdata, mem_valid, mem_ready, ram_addr, ram_oe, ram_we, ram_wdata,
           io_addr, io_we, io_wdata, io_req
  );
endinterface

// File: rtl/dmem_bridge_io_fsm.sv
// MMIO handshake FSM (IDLE -> IO_REQ -> IO_RESP). Defining IO_TIMEOUT_EN adds
// a wait counter that ends an unanswered request with the DEADBEEF error word.
module io_fsm
  import dmem_bridge_pkg::*;
`ifdef IO_TIMEOUT_EN
#(
  parameter int IO_TIMEOUT = 255
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_we,
  input  logic [31:0] i_wdata,
  input  logic        i_io_ack,
  input  logic [31:0] i_io_rdata,
  output logic        o_io_req,
  output logic [31:0] o_io_addr,
  output logic [3:0]  o_io_we,
  output logic [31:0] o_io_wdata,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_rdata
);

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

`ifdef IO_TIMEOUT_EN
  localparam int CNT_W = (IO_TIMEOUT > 0) ? $clog2(IO_TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;

  always_ff @(posedge clk) begin
    if (rst || r_state != ST_IO_REQ) r_cnt <= '0;
    else                             r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_cnt == CNT_W'(IO_TIMEOUT));
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_we    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        // IO_RESP still shows mem_ready, so a new MMIO request may chain directly.
        ST_IDLE, ST_IO_RESP: begin
          if (i_start) begin
            r_state <= ST_IO_REQ;
            r_addr  <= i_addr;
            r_we    <= i_we;
            r_wdata <= i_wdata;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_IO_REQ: begin
          if (i_io_ack) begin
            r_state <= ST_IO_RESP;
            if (r_we == 4'b0) r_rdata <= i_io_rdata;
          end
`ifdef IO_TIMEOUT_EN
          else if (w_timeout) begin
            r_state <= ST_IO_RESP;
            r_rdata <= IO_ERR_DATA;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_io_req   = (r_state == ST_IO_REQ);
  assign o_io_addr  = r_addr;
  assign o_io_we    = r_we;
  assign o_io_wdata = r_wdata;
  assign o_ready    = (r_state != ST_IO_REQ);
  assign o_valid    = (r_state == ST_IO_RESP) && (r_we == 4'b0);
  assign o_rdata    = r_rdata;

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: decodes processor accesses to a single-cycle data RAM or
// an MMIO handshake. Optional macro IO_TIMEOUT_EN enables the MMIO wait timeout.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int         RAM_AW     = 16,
  parameter logic [3:0] IO_BASE    = IO_BASE_DEFAULT,
  parameter int         IO_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  dmem_bridge_if.slave bus
);

  if (IO_TIMEOUT < 1) begin : g_bad_timeout
    $error("dmem_bridge: IO_TIMEOUT must be at least 1");
  end

  logic        w_req;
  logic        w_is_io;
  logic        w_ready;
  logic        w_accept;
  logic        w_ram_acc;
  logic        w_io_acc;
  logic        w_io_valid;
  logic [31:0] w_io_rdata;
  logic        r_ram_rd;

  assign w_req     = |bus.mem_oe;
  assign w_is_io   = is_io_region(bus.mem_addr[31:28], IO_BASE);
  // Requests seen while busy or in reset are dropped, never queued.
  assign w_accept  = w_req && w_ready && !rst;
  assign w_ram_acc = w_accept && !w_is_io;
  assign w_io_acc  = w_accept && w_is_io;

  assign bus.ram_addr  = bus.mem_addr[RAM_AW-1:0];
  assign bus.ram_oe    = w_ram_acc ? bus.mem_oe : 4'b0;
  assign bus.ram_we    = w_ram_acc ? bus.mem_we : 4'b0;
  assign bus.ram_wdata = bus.mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_ram_rd <= 1'b0;
    else     r_ram_rd <= w_ram_acc && (bus.mem_we == 4'b0);
  end

  // RAM read data has priority; it can never coincide with an MMIO response.
  assign bus.mem_valid = r_ram_rd || w_io_valid;
  assign bus.mem_rdata = r_ram_rd ? bus.ram_rdata : w_io_rdata;
  assign bus.mem_ready = w_ready;

`ifdef IO_TIMEOUT_EN
  io_fsm #(.IO_TIMEOUT(IO_TIMEOUT)) u_io_fsm (
`else
  io_fsm u_io_fsm (
`endif
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_io_acc),
    .i_addr     (bus.mem_addr),
    .i_we       (bus.mem_we),
    .i_wdata    (bus.mem_wdata),
    .i_io_ack   (bus.io_ack),
    .i_io_rdata (bus.io_rdata),
    .o_io_req   (bus.io_req),
    .o_io_addr  (bus.io_addr),
    .o_io_we    (bus.io_we),
    .o_io_wdata (bus.io_wdata),
    .o_ready    (w_ready),
    .o_valid    (w_io_valid),
    .o_rdata    (w_io_rdata)
  );

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: a cycle-indexed expectation timeline
// built from the latency rules, a per-cycle compare loop and literal checks.
module tb_dmem_bridge;

  localparam int RAM_AW = 16;
`ifdef IO_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif
  localparam int NCYC = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dmem_bridge_if #(.RAM_AW(RAM_AW)) bus ();

  dmem_bridge #(
    .RAM_AW    (RAM_AW),
    .IO_BASE   (4'h8),
    .IO_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data RAM: one-cycle read latency, byte-lane writes.
  logic [31:0] ram_mem [64];
  always @(posedge clk) begin
    if (bus.ram_oe != 4'b0) begin
      if (bus.ram_we == 4'b0) bus.ram_rdata <= ram_mem[bus.ram_addr[7:2]];
      else
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b]) ram_mem[bus.ram_addr[7:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end

  // Expected per-cycle behaviour, indexed by cycle number.
  bit          exp_valid [NCYC];
  logic [31:0] exp_rdata [NCYC];
  bit          exp_ready [NCYC];
  bit          exp_ioreq [NCYC];
  logic [3:0]  exp_oe    [NCYC];
  logic [3:0]  exp_we    [NCYC];
  logic [31:0] exp_raddr [NCYC];
  logic [31:0] shadow    [64];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int rdy_low_cnt = 0;
  int ioreq_cnt   = 0;
  int valid_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("mem_valid", 32'(bus.mem_valid), 32'(exp_valid[cyc]));
      if (exp_valid[cyc]) check("mem_rdata", bus.mem_rdata, exp_rdata[cyc]);
      check("mem_ready", 32'(bus.mem_ready), 32'(exp_ready[cyc]));
      check("io_req", 32'(bus.io_req), 32'(exp_ioreq[cyc]));
      check("ram_oe", 32'(bus.ram_oe), 32'(exp_oe[cyc]));
      check("ram_we", 32'(bus.ram_we), 32'(exp_we[cyc]));
      if (exp_oe[cyc] != 4'b0) check("ram_addr", 32'(bus.ram_addr), exp_raddr[cyc]);
      if (!bus.mem_ready) rdy_low_cnt++;
      if (bus.io_req)     ioreq_cnt++;
      if (bus.mem_valid)  valid_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata);
    int c;
    int idx;
    c   = cyc;
    idx = int'(addr[7:2]);
    bus.mem_addr  = addr;
    bus.mem_oe    = 4'hF;
    bus.mem_we    = we;
    bus.mem_wdata = wdata;
    exp_oe[c]    = 4'hF;
    exp_we[c]    = we;
    exp_raddr[c] = 32'(addr[RAM_AW-1:0]);
    if (we == 4'b0) begin
      exp_valid[c+1] = 1'b1;
      exp_rdata[c+1] = shadow[idx];
    end else begin
      for (int b = 0; b < 4; b++)
        if (we[b]) shadow[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    next_cycle();
    bus.mem_oe = 4'b0;
    bus.mem_we = 4'b0;
  endtask

  // MMIO access acked 'dly' cycles after io_req rises; optionally pokes a
  // RAM request while the bridge is busy, which must be ignored.
  task automatic mmio(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                      input int dly, input logic [31:0] rdata, input bit poke);
    int c;
    c = cyc;
    bus.mem_addr  = addr;
    bus.mem_oe    = 4'hF;
    bus.mem_we    = we;
    bus.mem_wdata = wdata;
    for (int k = c + 1; k <= c + 1 + dly; k++) begin
      exp_ready[k] = 1'b0;
      exp_ioreq[k] = 1'b1;
    end
    if (we == 4'b0) begin
      exp_valid[c+2+dly] = 1'b1;
      exp_rdata[c+2+dly] = rdata;
    end
    next_cycle();
    bus.mem_oe = 4'b0;
    bus.mem_we = 4'b0;
    check("io_addr", bus.io_addr, addr);
    check("io_we", 32'(bus.io_we), 32'(we));
    if (we != 4'b0) check("io_wdata", bus.io_wdata, wdata);
    if (poke) begin
      bus.mem_addr = 32'h0000_0010;
      bus.mem_oe   = 4'hF;
    end
    repeat (dly) next_cycle();
    bus.io_ack   = 1'b1;
    bus.io_rdata = rdata;
    next_cycle();
    bus.io_ack   = 1'b0;
    bus.io_rdata = 32'h0BAD_0BAD;
    bus.mem_oe   = 4'b0;
  endtask

  initial begin
    int s_rdy, s_ioreq, s_valid, c;
    for (int i = 0; i < NCYC; i++) begin
      exp_valid[i] = 1'b0;
      exp_rdata[i] = '0;
      exp_ready[i] = 1'b1;
      exp_ioreq[i] = 1'b0;
      exp_oe[i]    = 4'b0;
      exp_we[i]    = 4'b0;
      exp_raddr[i] = '0;
    end
    bus.mem_addr  = '0;
    bus.mem_oe    = 4'b0;
    bus.mem_we    = 4'b0;
    bus.mem_wdata = '0;
    bus.io_ack    = 1'b0;
    bus.io_rdata  = '0;
    rst = 1'b1;
    repeat (2) next_cycle();

    // Reset values, with a RAM request present that must stay gated.
    bus.mem_addr = 32'h0000_0010;
    bus.mem_oe   = 4'hF;
    bus.mem_we   = 4'hF;
    #1;
    check("rst mem_ready", 32'(bus.mem_ready), 32'd1);
    check("rst mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst io_req", 32'(bus.io_req), 32'd0);
    check("rst mem_rdata", bus.mem_rdata, 32'h0);
    check("rst ram_oe", 32'(bus.ram_oe), 32'd0);
    check("rst ram_we", 32'(bus.ram_we), 32'd0);
    bus.mem_oe = 4'b0;
    bus.mem_we = 4'b0;
    next_cycle();
    rst    = 1'b0;
    chk_en = 1'b1;
    next_cycle();

    // Seed RAM, then three back-to-back writes with varied lanes.
    ram_access(32'h0000_0010, 4'hF, 32'h1234_5678);
    s_rdy = rdy_low_cnt; s_valid = valid_cnt;
    ram_access(32'h0000_0020, 4'hF, 32'h1111_1111);
    ram_access(32'h0000_0024, 4'hF, 32'h2222_2222);
    ram_access(32'h0000_0024, 4'h3, 32'hAAAA_BBBB);
    next_cycle();
    check("b2b wr ready drops", 32'(rdy_low_cnt - s_rdy), 32'd0);
    check("b2b wr valid pulses", 32'(valid_cnt - s_valid), 32'd0);

    // Single RAM read, then back-to-back reads including a merged word.
    ram_access(32'h0000_0010, 4'h0, 32'h0);
    check("ram rd valid", 32'(bus.mem_valid), 32'd1);
    check("ram rd data", bus.mem_rdata, 32'h1234_5678);
    check("ram rd ready", 32'(bus.mem_ready), 32'd1);
    ram_access(32'h0000_0024, 4'h0, 32'h0);
    check("ram rd merged", bus.mem_rdata, 32'h2222_BBBB);
    ram_access(32'h0000_0020, 4'h0, 32'h0);
    next_cycle();

    // MMIO read, ack 3 cycles after io_req.
    s_rdy = rdy_low_cnt;
    mmio(32'h8000_0004, 4'h0, 32'h0, 3, 32'h0000_00A5, 1'b0);
    check("mmio rd valid", 32'(bus.mem_valid), 32'd1);
    check("mmio rd data", bus.mem_rdata, 32'h0000_00A5);
    check("mmio rd ready low cycles", 32'(rdy_low_cnt - s_rdy), 32'd4);
    next_cycle();

    // MMIO write acked on the first io_req cycle.
    s_ioreq = ioreq_cnt; s_valid = valid_cnt;
    mmio(32'h8000_0100, 4'hC, 32'hFEED_0001, 0, 32'h0, 1'b0);
    next_cycle();
    check("mmio wr io_req cycles", 32'(ioreq_cnt - s_ioreq), 32'd1);
    check("mmio wr valid pulses", 32'(valid_cnt - s_valid), 32'd0);
    check("mmio wr back to idle", 32'({bus.mem_ready, bus.io_req}), 32'b10);

    // RAM read valid in the MMIO acceptance cycle; poke while busy.
    ram_access(32'h0000_0020, 4'h0, 32'h0);
    check("overlap ram data", bus.mem_rdata, 32'h1111_1111);
    mmio(32'h8000_0010, 4'h0, 32'h0, 1, 32'hCAFE_F00D, 1'b1);
    check("overlap mmio data", bus.mem_rdata, 32'hCAFE_F00D);
    next_cycle();

    // Reset during IO_REQ, followed by a late ack.
    s_valid = valid_cnt;
    c = cyc;
    bus.mem_addr = 32'h8000_0200;
    bus.mem_oe   = 4'hF;
    for (int k = c + 1; k <= c + 3; k++) begin
      exp_ready[k] = 1'b0;
      exp_ioreq[k] = 1'b1;
    end
    next_cycle();
    bus.mem_oe = 4'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst          = 1'b0;
    bus.io_ack   = 1'b1;
    bus.io_rdata = 32'h0000_0BAD;
    check("abort io_req", 32'(bus.io_req), 32'd0);
    check("abort mem_ready", 32'(bus.mem_ready), 32'd1);
    next_cycle();
    bus.io_ack = 1'b0;
    repeat (3) next_cycle();
    check("abort valid pulses", 32'(valid_cnt - s_valid), 32'd0);

    // Recovery, then decode boundaries just outside the MMIO region.
    mmio(32'h8FFF_FFF0, 4'h0, 32'h0, 2, 32'h5A5A_1234, 1'b0);
    check("recover mmio data", bus.mem_rdata, 32'h5A5A_1234);
    ram_access(32'h7000_0010, 4'h0, 32'h0);
    check("below io region", bus.mem_rdata, 32'h1234_5678);
    ram_access(32'h9001_0024, 4'h0, 32'h0);
    check("above io region", bus.mem_rdata, 32'h2222_BBBB);
    next_cycle();

`ifdef IO_TIMEOUT_EN
    // Unanswered MMIO read ends with the error word.
    c = cyc;
    bus.mem_addr = 32'h8000_0040;
    bus.mem_oe   = 4'hF;
    for (int k = c + 1; k <= c + 5; k++) begin
      exp_ready[k] = 1'b0;
      exp_ioreq[k] = 1'b1;
    end
    exp_valid[c+6] = 1'b1;
    exp_rdata[c+6] = 32'hDEAD_BEEF;
    next_cycle();
    bus.mem_oe = 4'b0;
    repeat (5) next_cycle();
    check("timeout valid", 32'(bus.mem_valid), 32'd1);
    check("timeout data", bus.mem_rdata, 32'hDEAD_BEEF);
    next_cycle();
`endif

    repeat (3) next_cycle();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
